debug_dump_sequencer: RTL and testbench

//  Debug-unit controller that dumps processor state word-by-word through the serial rx buffer.
//  On request it walks three sources in order: register file, data memory, pipeline latches.
//  For each word it drives source select/address, captures the read data and pulses the buffer start.
//  It then waits for the buffer to drain before fetching the next word.

---
 rtl/debug_dump_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_debug_dump_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_sequencer.sv
// rtl/debug_dump_sequencer.sv - dumps register file, data memory and pipeline latches word-by-word into the rx buffer
// Define DUMP_CHECKSUM_EN to append a final XOR checksum word (sel=11, addr=0).
module debug_dump_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_COUNT   = 32,
  parameter int MEM_WORDS   = 32,
  parameter int LATCH_WORDS = 8,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_dump_req,
  input  logic                  i_dump_abort,
  input  logic [DATA_WIDTH-1:0] i_src_data,
  input  logic                  i_buf_empty,
  output logic [1:0]            o_src_sel,
  output logic [ADDR_WIDTH-1:0] o_src_addr,
  output logic                  o_buf_start,
  output logic [DATA_WIDTH-1:0] o_buf_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic [7:0]            o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPTURE,
    S_LOAD,
    S_WAIT,
    S_FINISH
  } state_t;

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_MEM   = 2'b01;
  localparam logic [1:0] SEL_LATCH = 2'b10;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [1:0] SEL_CSUM  = 2'b11;
`endif

  localparam logic [ADDR_WIDTH-1:0] REG_LAST   = ADDR_WIDTH'(REG_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_LAST   = ADDR_WIDTH'(MEM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LATCH_LAST = ADDR_WIDTH'(LATCH_WORDS - 1);

  state_t                  state, state_nxt;
  logic [1:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [7:0]              count_q;
  logic                    abort_q;
  logic                    finish_abort_q;
  logic                    abort_now;
  logic                    last_word;
  logic                    accept;
  logic                    advance;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q;
`endif

  assign abort_now = abort_q | i_dump_abort;

`ifdef DUMP_CHECKSUM_EN
  assign last_word = (sel_q == SEL_CSUM);
`else
  assign last_word = (sel_q == SEL_LATCH) && (addr_q == LATCH_LAST);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_buf_start = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_aborted   = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_dump_req && i_buf_empty) begin
          accept    = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_LOAD;
      S_LOAD: begin
        o_buf_start = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        // A pending abort only takes effect once the current word has drained.
        if (i_buf_empty) begin
          if (last_word || abort_now) begin
            state_nxt = S_FINISH;
          end else begin
            advance   = 1'b1;
            state_nxt = S_ADDR;
          end
        end
      end
      S_FINISH: begin
        o_busy    = 1'b0;
        o_done    = ~finish_abort_q;
        o_aborted = finish_abort_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sel_q          <= SEL_REG;
      addr_q         <= '0;
      data_q         <= '0;
      count_q        <= '0;
      abort_q        <= 1'b0;
      finish_abort_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else if (accept) begin
      sel_q   <= SEL_REG;
      addr_q  <= '0;
      count_q <= '0;
      abort_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      if (state != S_IDLE && i_dump_abort) abort_q <= 1'b1;

      if (state == S_CAPTURE) begin
`ifdef DUMP_CHECKSUM_EN
        data_q <= (sel_q == SEL_CSUM) ? csum_q : i_src_data;
        if (sel_q != SEL_CSUM) csum_q <= csum_q ^ i_src_data;
`else
        data_q <= i_src_data;
`endif
      end

      if (o_buf_start && count_q != 8'hFF) count_q <= count_q + 8'd1;

      // Last word wins over a simultaneous abort.
      if (state == S_WAIT && i_buf_empty) finish_abort_q <= abort_now && !last_word;

      if (advance) begin
        case (sel_q)
          SEL_REG: begin
            if (addr_q == REG_LAST) begin
              sel_q  <= SEL_MEM;
              addr_q <= '0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          SEL_MEM: begin
            if (addr_q == MEM_LAST) begin
              sel_q  <= SEL_LATCH;
              addr_q <= '0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          default: begin
`ifdef DUMP_CHECKSUM_EN
            if (addr_q == LATCH_LAST) begin
              sel_q  <= SEL_CSUM;
              addr_q <= '0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
`else
            addr_q <= addr_q + 1'b1;
`endif
          end
        endcase
      end
    end
  end

  assign o_src_sel    = sel_q;
  assign o_src_addr   = addr_q;
  assign o_buf_data   = data_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb/tb_debug_dump_sequencer.sv - scoreboard bench for debug_dump_sequencer
// Expected words are queued by the stimulus; a negedge monitor pops and compares on every buffer start.
module tb_debug_dump_sequencer;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef DUMP_CHECKSUM_EN
  localparam int TOTAL = 73;
`else
  localparam int TOTAL = 72;
`endif

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dump_req = 1'b0;
  logic          dump_abort = 1'b0;
  logic          hold_full = 1'b0;
  logic          buf_empty_m;
  logic          buf_empty;
  logic [DW-1:0] src_data;
  logic [1:0]    src_sel;
  logic [AW-1:0] src_addr;
  logic          buf_start;
  logic [DW-1:0] buf_data;
  logic          busy, done, aborted;
  logic [7:0]    word_count;
  int            drain;

  word_t exp_q[$];
  word_t mon_w;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    starts_seen = 0;
  int    done_cnt = 0;
  int    abort_cnt = 0;
  int    prev_start = -1;
  int    req_cyc = 0;
  bit    first_pending = 1'b0;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  debug_dump_sequencer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_dump_req   (dump_req),
    .i_dump_abort (dump_abort),
    .i_src_data   (src_data),
    .i_buf_empty  (buf_empty),
    .o_src_sel    (src_sel),
    .o_src_addr   (src_addr),
    .o_buf_start  (buf_start),
    .o_buf_data   (buf_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_aborted    (aborted),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] src_word(input logic [1:0] s, input logic [AW-1:0] a);
    return {6'h2A, s, 3'b101, a, 16'h1357 ^ {a, 11'h5A3}};
  endfunction

  // Source memories answer one cycle after the address.
  always @(posedge clk) src_data <= src_word(src_sel, src_addr);

  // Rx buffer: goes non-empty on the edge that samples start, drains 33 cycles later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_empty_m <= 1'b1;
      drain       <= 0;
    end else if (buf_start) begin
      buf_empty_m <= 1'b0;
      drain       <= 33;
    end else if (drain != 0) begin
      drain <= drain - 1;
      if (drain == 1) buf_empty_m <= 1'b1;
    end
  end
  assign buf_empty = buf_empty_m & ~hold_full;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (buf_start) begin
        starts_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: got sel=%0d addr=%0d data=%0h, expected no start", src_sel, src_addr, buf_data);
        end else begin
          mon_w = exp_q.pop_front();
          check("start_sel", src_sel, mon_w.sel);
          check("start_addr", src_addr, mon_w.addr);
          check("start_data", buf_data, mon_w.data);
        end
        if (first_pending) begin
          check("req_to_start_latency", cyc - req_cyc, 3);
          first_pending = 1'b0;
        end else if (prev_start >= 0) begin
          check("empty_to_start_gap", cyc - prev_start, 37);
        end
        prev_start = cyc;
      end
      if (done || aborted) begin
        done_cnt  += int'(done);
        abort_cnt += int'(aborted);
        check("busy_low_at_finish", busy, 0);
        check("done_and_aborted_exclusive", done & aborted, 0);
        prev_start = -1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_range(input logic [1:0] s, input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sel  = s;
      w.addr = AW'(i);
      w.data = src_word(s, AW'(i));
`ifdef DUMP_CHECKSUM_EN
      csum = csum ^ w.data;
`endif
      exp_q.push_back(w);
    end
  endtask

  task automatic push_full();
`ifdef DUMP_CHECKSUM_EN
    word_t w;
    csum = '0;
`endif
    push_range(2'b00, 32);
    push_range(2'b01, 32);
    push_range(2'b10, 8);
`ifdef DUMP_CHECKSUM_EN
    w.sel  = 2'b11;
    w.addr = '0;
    w.data = csum;
    exp_q.push_back(w);
`endif
  endtask

  task automatic start_dump();
    @(negedge clk);
    dump_req      = 1'b1;
    req_cyc       = cyc;
    first_pending = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int t = 0;
    while (starts_seen < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, starts_seen >= target, 1);
  endtask

  task automatic wait_finish(input int budget, input string name);
    int t = 0;
    int target = done_cnt + abort_cnt + 1;
    while ((done_cnt + abort_cnt) < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, (done_cnt + abort_cnt) >= target, 1);
  endtask

  task automatic pulse_abort();
    dump_abort = 1'b1;
    tick(1);
    dump_abort = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sel"}, src_sel, 0);
    check({tag, "_addr"}, src_addr, 0);
    check({tag, "_start"}, buf_start, 0);
    check({tag, "_data"}, buf_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
    check({tag, "_count"}, word_count, 0);
  endtask

  initial begin
    int base;
    int t;
    tick(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Abort in IDLE must be ignored; then a full dump.
    pulse_abort();
    tick(2);
    push_full();
    start_dump();
    wait_finish(4000, "full_dump_finish");
    check("full_done_cnt", done_cnt, 1);
    check("full_abort_cnt", abort_cnt, 0);
    check("full_word_count", word_count, TOTAL);
    check("full_queue_drained", exp_q.size(), 0);
    tick(1);
    check("full_busy_after", busy, 0);

    // Abort during word 5.
    base = starts_seen;
    push_range(2'b00, 5);
    start_dump();
    wait_starts(base + 5, 400, "abort5_reach_word5");
    pulse_abort();
    wait_finish(400, "abort5_finish");
    check("abort5_abort_cnt", abort_cnt, 1);
    check("abort5_done_cnt", done_cnt, 1);
    check("abort5_word_count", word_count, 5);
    tick(60);
    check("abort5_no_more_starts", starts_seen, base + 5);

    // Abort during WAIT of the final word: done wins.
    base = starts_seen;
    push_full();
    start_dump();
    wait_starts(base + TOTAL, 4000, "lastabort_reach_last");
    pulse_abort();
    wait_finish(400, "lastabort_finish");
    check("lastabort_done_cnt", done_cnt, 2);
    check("lastabort_abort_cnt", abort_cnt, 1);
    check("lastabort_word_count", word_count, TOTAL);

    // Request held while buffer not empty, then re-request while busy.
    base = starts_seen;
    hold_full = 1'b1;
    tick(1);
    dump_req = 1'b1;
    tick(10);
    check("notempty_busy", busy, 0);
    check("notempty_no_start", starts_seen, base);
    push_range(2'b00, 1);
    hold_full     = 1'b0;
    req_cyc       = cyc;
    first_pending = 1'b1;
    t = 0;
    while (!busy && t < 20) begin
      tick(1);
      t++;
    end
    check("notempty_accept", busy, 1);
    pulse_abort();
    tick(4);
    dump_req = 1'b0;
    wait_finish(400, "notempty_finish");
    check("notempty_abort_cnt", abort_cnt, 2);
    check("notempty_word_count", word_count, 1);
    tick(50);
    check("busyreq_ignored_starts", starts_seen, base + 1);
    check("busyreq_ignored_busy", busy, 0);

    // Reset in the middle of WAIT.
    base = starts_seen;
    push_range(2'b00, 2);
    start_dump();
    wait_starts(base + 2, 200, "reset_reach_word2");
    tick(5);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    tick(2);
    reset      = 1'b0;
    prev_start = -1;
    tick(3);
    check_idle_outputs("postreset");
    check("postreset_done_cnt", done_cnt, 2);
    check("postreset_abort_cnt", abort_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
